// File: rtl/circuit_a_2_pkg.sv
// Circuit A (second implementation) shared constants.
// Truth table of F, bit i = F({A,B,C,D} == i).
package circuit_a_2_pkg;

    localparam int unsigned N_IN = 4;

    // Ones at 2,4,5,6,7,9,10,11,14.
    localparam logic [15:0] F_TT = 16'b0100_1110_1111_0100;

    // Look up the reference value of F for one input code.
    function automatic logic f_ref(input logic [N_IN-1:0] code);
        return F_TT[code];
    endfunction

endpackage

// File: rtl/circuit_a_2_logic.sv
// Circuit A combinational core.
// Produces F in sum-of-products and product-of-maxterms forms.
module circuit_a_2_logic
    import circuit_a_2_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic f_sop,
    output logic f_pos
);

    logic [6:0] maxterm;

    // Minimal SOP form of the function.
    always_comb begin
        f_sop = (~a & b) | (c & ~d) | (a & ~b & d);
    end

    // Maxterms for codes 0,1,3,8,12,13,15, ANDed together.
    always_comb begin
        maxterm[0] =  a |  b |  c |  d;
        maxterm[1] =  a |  b |  c | ~d;
        maxterm[2] =  a |  b | ~c | ~d;
        maxterm[3] = ~a |  b |  c |  d;
        maxterm[4] = ~a | ~b |  c |  d;
        maxterm[5] = ~a | ~b |  c | ~d;
        maxterm[6] = ~a | ~b | ~c | ~d;
        f_pos      = &maxterm;
    end

endmodule

// File: rtl/circuit_a_2.sv
// Circuit A top: combinational F, registered F_q,
// and a sticky flag when the SOP and POS forms disagree.
module circuit_a_2
    import circuit_a_2_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic F,
    output logic F_q,
    output logic err_q
);

    logic f_sop;
    logic f_pos;

    circuit_a_2_logic u_logic (
        .a     (A),
        .b     (B),
        .c     (C),
        .d     (D),
        .f_sop (f_sop),
        .f_pos (f_pos)
    );

    // F follows the SOP form with no clock dependence.
    always_comb begin
        F = f_sop;
    end

    // Register F; reset clears the copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            F_q <= 1'b0;
        end else begin
            F_q <= f_sop;
        end
    end

    // Latch any SOP/POS disagreement until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (f_sop != f_pos) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_circuit_a_2.sv
// Directed bench for circuit_a_2.
// Expected values are hand-derived from the minterm list.
module tb_circuit_a_2;

    logic clk;
    logic reset;
    logic A, B, C, D;
    logic F, F_q, err_q;

    int n_cmp;
    int n_bad;

    // Hand-built: ones at 2,4,5,6,7,9,10,11,14.
    logic [15:0] exp_tt;

    circuit_a_2 dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .C     (C),
        .D     (D),
        .F     (F),
        .F_q   (F_q),
        .err_q (err_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] code);
        {A, B, C, D} = code;
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        exp_tt = 16'b0100_1110_1111_0100;
        reset  = 1'b1;
        drive(4'd2);

        // Reset state; F is live even under reset.
        @(negedge clk);
        @(negedge clk);
        check("rst_F_q", F_q, 1'b0);
        check("rst_err_q", err_q, 1'b0);
        check("rst_F_live", F, 1'b1);

        // Exhaustive sweep, 100 ns per code, clock running.
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(4'(i));
            #1;
            check($sformatf("sweep_F_%0d", i), F, exp_tt[i]);
            #98;
            check($sformatf("sweep_F_q_%0d", i), F_q, exp_tt[i]);
            check($sformatf("sweep_err_%0d", i), err_q, 1'b0);
            #1;
        end

        // Spot checks.
        drive(4'd0);  #1; check("spot_0", F, 1'b0);
        drive(4'd2);  #1; check("spot_2", F, 1'b1);
        drive(4'd9);  #1; check("spot_9", F, 1'b1);
        drive(4'd13); #1; check("spot_13", F, 1'b0);
        drive(4'd15); #1; check("spot_15", F, 1'b0);

        // Registered path: 0100 then 1101.
        @(negedge clk);
        check("reg_pre", F_q, 1'b0);
        drive(4'b0100);
        @(negedge clk);
        check("reg_0100", F_q, 1'b1);
        drive(4'b1101);
        @(negedge clk);
        check("reg_1101", F_q, 1'b0);

        // Mid-operation reset for one edge.
        drive(4'b0100);
        @(negedge clk);
        check("pre_rst_F_q", F_q, 1'b1);
        check("pre_rst_F", F, 1'b1);
        reset = 1'b1;
        #1;
        check("in_rst_F", F, 1'b1);
        @(negedge clk);
        check("mid_rst_F_q", F_q, 1'b0);
        check("mid_rst_err", err_q, 1'b0);
        check("mid_rst_F", F, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_F_q", F_q, 1'b1);

        // Hold code 10 for 20 cycles.
        drive(4'd10);
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check($sformatf("hold_F_%0d", k), F, 1'b1);
            check($sformatf("hold_F_q_%0d", k), F_q, 1'b1);
            check($sformatf("hold_err_%0d", k), err_q, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
